// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick / clock-enable generator.
package tick_gen_pkg;

  localparam int CNT_W = 28;

  typedef logic [CNT_W-1:0] cnt_t;

  // 1 s period, 50 % duty at a 100 MHz system clock
  localparam cnt_t DEF_DIV  = cnt_t'(100_000_000);
  localparam cnt_t DEF_HIGH = cnt_t'(50_000_000);

  typedef struct packed {
    cnt_t div;
    cnt_t high;
  } chan_cfg_t;

  // A period needs at least two counts, and the high time cannot exceed the period
  function automatic logic cfg_values_ok(input cnt_t div, input cnt_t high);
    return (div >= cnt_t'(2)) && (high <= div);
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: free-running counter, shadow/active configuration with a
// pending flag, and registered square-wave and strobe outputs.
module tick_gen_ch #(
  parameter tick_gen_pkg::cnt_t DEF_DIV  = tick_gen_pkg::DEF_DIV,
  parameter tick_gen_pkg::cnt_t DEF_HIGH = tick_gen_pkg::DEF_HIGH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic                   i_sync,
  input  logic                   i_wr,
  input  tick_gen_pkg::chan_cfg_t i_cfg,
  output logic                   o_outclk,
  output logic                   o_tick
);
  import tick_gen_pkg::*;

  localparam chan_cfg_t RST_CFG = '{div: DEF_DIV, high: DEF_HIGH};

  cnt_t      r_cnt;
  chan_cfg_t r_act;
  chan_cfg_t r_shd;
  logic      r_pend;
  logic      r_outclk;
  logic      r_tick;

  cnt_t      w_cnt_next;
  chan_cfg_t w_act_next;
  chan_cfg_t w_shd_next;
  logic      w_pend_next;
  logic      w_outclk_next;
  logic      w_tick_next;
  logic      w_last;

  assign w_last = (r_cnt == (r_act.div - cnt_t'(1)));

  // Next-state: sync beats wrap beats count; a write in the same cycle lands after any transfer
  always_comb begin
    w_cnt_next    = r_cnt;
    w_act_next    = r_act;
    w_shd_next    = r_shd;
    w_pend_next   = r_pend;
    w_outclk_next = 1'b0;
    w_tick_next   = 1'b0;

    if (!i_en) begin
      // Idle channel: hold at count 0 and take any pending config straight away
      w_cnt_next = '0;
      if (r_pend) begin
        w_act_next  = r_shd;
        w_pend_next = 1'b0;
      end
    end else begin
      w_outclk_next = (r_cnt < r_act.high);
      // A sync-truncated period never produces a strobe
      w_tick_next   = w_last && !i_sync;
      if (i_sync || w_last) begin
        w_cnt_next = '0;
        if (r_pend) begin
          w_act_next  = r_shd;
          w_pend_next = 1'b0;
        end
      end else begin
        w_cnt_next = r_cnt + cnt_t'(1);
      end
    end

    if (i_wr) begin
      w_shd_next  = i_cfg;
      w_pend_next = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_act    <= RST_CFG;
      r_shd    <= RST_CFG;
      r_pend   <= 1'b0;
      r_outclk <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_act    <= w_act_next;
      r_shd    <= w_shd_next;
      r_pend   <= w_pend_next;
      r_outclk <= w_outclk_next;
      r_tick   <= w_tick_next;
    end
  end

  assign o_outclk = r_outclk;
  assign o_tick   = r_tick;

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable clock-enable / strobe generator: validates and
// decodes config writes, instantiates one divider per channel.
module multi_tick_gen #(
  parameter int                 NUM_CH   = 4,
  parameter tick_gen_pkg::cnt_t DEF_DIV  = tick_gen_pkg::DEF_DIV,
  parameter tick_gen_pkg::cnt_t DEF_HIGH = tick_gen_pkg::DEF_HIGH,
  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic [CH_W-1:0]           cfg_ch,
  input  tick_gen_pkg::cnt_t        cfg_div,
  input  tick_gen_pkg::cnt_t        cfg_high,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         outclk,
  output logic [NUM_CH-1:0]         tick,
  output logic                      cfg_err
);
  import tick_gen_pkg::*;

  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  chan_cfg_t         w_cfg;
  logic              w_vals_ok;
  logic              w_ch_bad;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_rej;
  logic              w_err_next;
  logic              r_cfg_err;

  assign w_cfg      = '{div: cfg_div, high: cfg_high};
  assign w_vals_ok  = cfg_values_ok(cfg_div, cfg_high);
  // Only reachable when NUM_CH is not a power of two
  assign w_ch_bad   = ({1'b0, cfg_ch} >= NUM_CH_EXT);
  assign w_err_next = (cfg_wr && w_ch_bad) || (|w_rej);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_sel;

      assign w_sel     = cfg_wr && (cfg_ch == CH_W'(gi));
      assign w_wr[gi]  = w_sel && w_vals_ok;
      assign w_rej[gi] = w_sel && !w_vals_ok;

      tick_gen_ch #(
        .DEF_DIV  (DEF_DIV),
        .DEF_HIGH (DEF_HIGH)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .i_en     (en[gi]),
        .i_sync   (sync),
        .i_wr     (w_wr[gi]),
        .i_cfg    (w_cfg),
        .o_outclk (outclk[gi]),
        .o_tick   (tick[gi])
      );
    end
  endgenerate

  // One-cycle reject pulse, registered so it follows the offending write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_err_next;
    end
  end

  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Randomised + directed bench for multi_tick_gen against a period-start-time model.
module tb_multi_tick_gen;
  import tick_gen_pkg::*;

  localparam int NCH     = 3;
  localparam int TB_DIV  = 12;
  localparam int TB_HIGH = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_wr = 1'b0;
  logic [1:0]     cfg_ch = '0;
  cnt_t           cfg_div = '0;
  cnt_t           cfg_high = '0;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] outclk;
  logic [NCH-1:0] tick;
  logic           cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each channel is described by the cycle its current period began
  int             m_div [NCH];
  int             m_high[NCH];
  int             m_sdiv[NCH];
  int             m_shigh[NCH];
  bit             m_pend[NCH];
  longint         m_t0  [NCH];
  longint         m_now = 0;
  logic [NCH-1:0] e_outclk = '0;
  logic [NCH-1:0] e_tick = '0;
  logic           e_err = 1'b0;

  always #5 clk = ~clk;

  multi_tick_gen #(
    .NUM_CH   (NCH),
    .DEF_DIV  (cnt_t'(TB_DIV)),
    .DEF_HIGH (cnt_t'(TB_HIGH))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .en       (en),
    .sync     (sync),
    .outclk   (outclk),
    .tick     (tick),
    .cfg_err  (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, m_now, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c]   = TB_DIV;
      m_high[c]  = TB_HIGH;
      m_sdiv[c]  = TB_DIV;
      m_shigh[c] = TB_HIGH;
      m_pend[c]  = 1'b0;
      m_t0[c]    = m_now;
    end
    e_outclk = '0;
    e_tick   = '0;
    e_err    = 1'b0;
  endtask

  task automatic apply_pending(input int c);
    if (m_pend[c]) begin
      m_div[c]  = m_sdiv[c];
      m_high[c] = m_shigh[c];
      m_pend[c] = 1'b0;
    end
  endtask

  // Predicts outputs after the coming edge from the inputs currently driven
  task automatic model_step();
    int ph;
    bit end_of_period;
    for (int c = 0; c < NCH; c++) begin
      ph = int'(m_now - m_t0[c]);
      end_of_period = (ph == m_div[c] - 1);
      if (!en[c]) begin
        e_outclk[c] = 1'b0;
        e_tick[c]   = 1'b0;
        m_t0[c]     = m_now + 1;
        apply_pending(c);
      end else begin
        e_outclk[c] = (ph < m_high[c]);
        e_tick[c]   = end_of_period && !sync;
        if (sync || end_of_period) begin
          m_t0[c] = m_now + 1;
          apply_pending(c);
        end
      end
    end
    e_err = 1'b0;
    if (cfg_wr) begin
      if (int'(cfg_ch) >= NCH || int'(cfg_div) < 2 || int'(cfg_high) > int'(cfg_div)) begin
        e_err = 1'b1;
      end else begin
        m_sdiv[cfg_ch]  = int'(cfg_div);
        m_shigh[cfg_ch] = int'(cfg_high);
        m_pend[cfg_ch]  = 1'b1;
      end
    end
    m_now++;
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("outclk", outclk, e_outclk);
    chk("tick", tick, e_tick);
    chk("cfg_err", cfg_err, e_err);
    cfg_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic wr(input int ch, input int div, input int high);
    cfg_wr   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = cnt_t'(div);
    cfg_high = cnt_t'(high);
    run_cycle();
  endtask

  task automatic check_async_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_outclk"}, outclk, '0);
    chk({tag, "_tick"}, tick, '0);
    chk({tag, "_err"}, cfg_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    // Reset state
    #2;
    check_async_reset("rst");

    // ch0 10/5 programmed while idle, then enabled
    wr(0, 10, 5); run(1);
    en = 3'b001; run(30);

    // ch1 reprogrammed mid-period: old period completes first
    wr(1, 10, 5); run(1);
    en = 3'b011; run(13);
    wr(1, 4, 1); run(30);

    // Rejected writes: div too small, high > div, channel out of range
    wr(0, 1, 0); wr(0, 6, 7); wr(3, 8, 4); run(12);

    // Edge duty cycles: constant high and constant low
    en = '0; wr(0, 8, 8); wr(2, 8, 0); run(1);
    en = 3'b101; run(24);

    // Phase alignment of ch0 (div 6) and ch2 (div 9)
    en = '0; wr(0, 6, 3); wr(2, 9, 4); run(1);
    en = 3'b101; run(7 + int'($urandom_range(0, 6)));
    sync = 1'b1; run(21);

    // Random traffic
    en = 3'b111;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
      if ($urandom_range(0, 99) == 0) sync = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 2'($urandom_range(0, 3));
        cfg_div  = cnt_t'($urandom_range(0, 20));
        cfg_high = cnt_t'($urandom_range(0, 22));
      end
      run_cycle();
    end

    // Reset mid-period with a write still pending: defaults must come back
    en = '0; wr(0, 12, 6); run(1);
    en = 3'b001; run(3);
    wr(0, 4, 2); run(2);
    #3;
    check_async_reset("midrst");
    en = 3'b111; run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
